point_detect_ctrl: RTL and testbench
====================================

POINT_DETECT_CTRL -- requirements
Module: point_detect_ctrl

Interface
REQ-001 Parameters (name, default, meaning): FRAME_SEL, 120, index of frame scanned after arm; THRESH, 8'd200, luma threshold (bright = luma >= THRESH); H_LAST, 10'd639, last active x; MAX_PTS, 4, point slots.
REQ-002 clk  in  1  pixel clock; one clock only.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 i_arm  in  1  one-cycle pulse starting a capture sequence.
REQ-005 i_vsync  in  1  one-cycle pulse at start of each frame.
REQ-006 i_valid  in  1  active pixel present; i_x  in  10  pixel x; i_y  in  10  pixel y; i_luma  in  8  pixel luma.
REQ-007 o_start  out  1  run-start pulse to point detector; o_finish  out  1  run-end pulse; o_left_edge  out  10  x of first bright pixel of current run; o_y  out  10  y of current run.
REQ-008 i_det_finished  in  1  detector result strobe; i_det_x  in  10  centre x; i_det_y  in  9  centre y.
REQ-009 i_rd_idx  in  2  result slot select; o_rd_x  out  10, o_rd_y  out  9  slot contents (combinational read); o_num_pts  out  3  valid slots; o_busy  out  1; o_done  out  1  level, sequence complete.

Function
REQ-010 FSM states IDLE, WAIT_FRAME, SCAN, DONE; reset state IDLE.
REQ-011 IDLE: i_arm -> WAIT_FRAME; frame counter cleared, o_num_pts cleared, slots retained until overwritten.
REQ-012 WAIT_FRAME: each i_vsync increments 7-bit frame counter; on i_vsync with counter == FRAME_SEL-1 -> SCAN.
REQ-013 SCAN: next i_vsync, or o_num_pts reaching MAX_PTS, -> DONE; i_vsync wins when coincident with the last slot write, the write still completing.
REQ-014 DONE: o_done = 1; i_arm -> WAIT_FRAME (re-arm); otherwise hold.
REQ-015 o_busy = 1 in WAIT_FRAME and SCAN, else 0.
REQ-016 Run tracking only in SCAN with i_valid=1: bright pixel while not in run -> in_run set, o_left_edge <= i_x, o_y <= i_y, o_start pulses next cycle (registered, latency 1).
REQ-017 Dark pixel while in run, or any pixel with i_x == H_LAST while in run or starting one -> in_run cleared, o_finish pulses next cycle.
REQ-018 Single-pixel run at x == H_LAST: o_start and o_finish SHALL assert in consecutive cycles (start first), never the same cycle.
REQ-019 i_valid=0 cycles SHALL not change run state; an open run at SCAN exit SHALL be closed with one o_finish pulse.
REQ-020 o_start/o_finish never asserted outside SCAN except the closing o_finish of REQ-019.
REQ-021 i_det_finished in SCAN with o_num_pts < MAX_PTS: slot[o_num_pts] <= {i_det_x, i_det_y}, o_num_pts += 1; strobes when full or outside SCAN ignored.
REQ-022 o_num_pts saturates at MAX_PTS; frame counter saturates at 127; i_rd_idx ≥ o_num_pts returns stale slot data.
REQ-023 i_arm while busy ignored.

Reset
REQ-024 rst low: state IDLE; all outputs 0; slots, counters, in_run, o_left_edge, o_y cleared to 0, effective asynchronously.
REQ-025 Reset mid-SCAN SHALL drop any open run with no o_finish pulse.

Structure
REQ-026 Shared package point_pkg holds FSM state enum, MAX_PTS, H_LAST, coordinate widths, and a point_t struct {x[9:0], y[8:0]}.
REQ-027 One sub-module: run_tracker (REQ-016..019) instantiated once; slot storage and FSM in top.

Verification
REQ-028 Arm, FRAME_SEL=3, three vsyncs -> o_busy=1, SCAN entered after third; no o_start before.
REQ-029 Row y=10, bright x=100..109 -> o_start 1 cycle after x=100 with o_left_edge=100, o_y=10; o_finish 1 cycle after x=110.
REQ-030 Bright run x=630..639 -> o_finish one cycle after x=639; bright only at x=639 -> o_start then o_finish next cycle.
REQ-031 Five i_det_finished strobes (x=50,60,70,80,90) -> slots hold 50..80, o_num_pts=4, DONE, fifth dropped.
REQ-032 Run open when vsync ends SCAN -> one closing o_finish, o_done=1, o_num_pts unchanged.
REQ-033 rst low mid-run -> all outputs 0 immediately, no o_finish after release, state IDLE.

Source files
------------

// File: rtl/point_pkg.sv
// Shared types and constants for the bright-point capture controller.
// Pure definitions: no latency, no flow control.
package point_pkg;

    localparam int          MAX_PTS = 4;
    localparam logic [9:0]  H_LAST  = 10'd639;
    localparam int          X_W     = 10;
    localparam int          Y_W     = 10;
    localparam int          PT_Y_W  = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_FRAME,
        ST_SCAN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]    x;
        logic [PT_Y_W-1:0] y;
    } point_t;

endpackage

// File: rtl/run_tracker.sv
// Bright-run tracker: start/finish pulses one cycle after the deciding pixel.
// No backpressure; pixels with i_valid low leave run state untouched.
module run_tracker #(
    parameter logic [7:0] THRESH = 8'd200,
    parameter logic [9:0] H_LAST = 10'd639
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_active,
    input  logic       i_valid,
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  logic [7:0] i_luma,
    output logic       o_start,
    output logic       o_finish,
    output logic [9:0] o_left_edge,
    output logic [9:0] o_y
);

    logic       in_run_q, in_run_d;
    logic       pend_q, pend_d;
    logic       start_q, start_d;
    logic       finish_q, finish_d;
    logic [9:0] left_q, left_d;
    logic [9:0] y_q, y_d;
    logic       bright, at_last, run_open;

    assign bright  = (i_luma >= THRESH);
    assign at_last = (i_x == H_LAST);

    always_comb begin
        in_run_d = in_run_q;
        pend_d   = pend_q;
        left_d   = left_q;
        y_d      = y_q;
        start_d  = 1'b0;
        finish_d = 1'b0;
        run_open = in_run_q && !pend_q;
        // A run begun on the last pixel, or left open when scanning stops, closes here.
        if (pend_q || (in_run_q && !i_active)) begin
            finish_d = 1'b1;
            in_run_d = 1'b0;
            pend_d   = 1'b0;
        end
        if (i_active && i_valid) begin
            if (!run_open) begin
                if (bright) begin
                    start_d  = 1'b1;
                    in_run_d = 1'b1;
                    left_d   = i_x;
                    y_d      = i_y;
                    pend_d   = at_last;
                end
            end else if (!bright || at_last) begin
                in_run_d = 1'b0;
                finish_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_run_q <= 1'b0;
            pend_q   <= 1'b0;
            start_q  <= 1'b0;
            finish_q <= 1'b0;
            left_q   <= '0;
            y_q      <= '0;
        end else begin
            in_run_q <= in_run_d;
            pend_q   <= pend_d;
            start_q  <= start_d;
            finish_q <= finish_d;
            left_q   <= left_d;
            y_q      <= y_d;
        end
    end

    assign o_start     = start_q;
    assign o_finish    = finish_q;
    assign o_left_edge = left_q;
    assign o_y         = y_q;

endmodule

// File: rtl/point_detect_ctrl.sv
// Arms on i_arm, scans frame FRAME_SEL, collects up to MAX_PTS detector results; outputs registered (1 cycle).
// No backpressure: detector strobes arriving when full or outside the scan frame are dropped.
module point_detect_ctrl #(
    parameter int         FRAME_SEL = 120,
    parameter logic [7:0] THRESH    = 8'd200,
    parameter logic [9:0] H_LAST    = point_pkg::H_LAST,
    parameter int         MAX_PTS   = point_pkg::MAX_PTS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_arm,
    input  logic       i_vsync,
    input  logic       i_valid,
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  logic [7:0] i_luma,
    output logic       o_start,
    output logic       o_finish,
    output logic [9:0] o_left_edge,
    output logic [9:0] o_y,
    input  logic       i_det_finished,
    input  logic [9:0] i_det_x,
    input  logic [8:0] i_det_y,
    input  logic [1:0] i_rd_idx,
    output logic [9:0] o_rd_x,
    output logic [8:0] o_rd_y,
    output logic [2:0] o_num_pts,
    output logic       o_busy,
    output logic       o_done
);
    import point_pkg::*;

    localparam int         IDX_W      = $clog2(MAX_PTS);
    localparam logic [6:0] FRAME_LAST = 7'(FRAME_SEL - 1);
    localparam logic [2:0] NUM_MAX    = 3'(MAX_PTS);

    state_t     state_q, state_d;
    logic [6:0] frm_q;
    logic [2:0] num_q;
    logic       busy_q, done_q;
    point_t     slot_q [MAX_PTS];
    logic       wr;

    assign wr = (state_q == ST_SCAN) && i_det_finished && (num_q < NUM_MAX);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (i_arm) state_d = ST_WAIT_FRAME;
            ST_WAIT_FRAME: if (i_vsync && frm_q == FRAME_LAST) state_d = ST_SCAN;
            // Filling the last slot and vsync both end the scan; the write lands either way.
            ST_SCAN:       if (i_vsync || (wr && num_q == NUM_MAX - 3'd1)) state_d = ST_DONE;
            ST_DONE:       if (i_arm) state_d = ST_WAIT_FRAME;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            frm_q   <= '0;
            num_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < MAX_PTS; i++) slot_q[i] <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == ST_WAIT_FRAME) || (state_d == ST_SCAN);
            done_q  <= (state_d == ST_DONE);
            if ((state_q == ST_IDLE || state_q == ST_DONE) && i_arm) begin
                frm_q <= '0;
                num_q <= '0;
            end else if (state_q == ST_WAIT_FRAME && i_vsync && frm_q != 7'd127) begin
                frm_q <= frm_q + 7'd1;
            end
            if (wr) begin
                slot_q[num_q[IDX_W-1:0]] <= '{x: i_det_x, y: i_det_y};
                num_q <= num_q + 3'd1;
            end
        end
    end

    run_tracker #(
        .THRESH (THRESH),
        .H_LAST (H_LAST)
    ) u_run_tracker (
        .clk         (clk),
        .rst         (rst),
        .i_active    (state_q == ST_SCAN),
        .i_valid     (i_valid),
        .i_x         (i_x),
        .i_y         (i_y),
        .i_luma      (i_luma),
        .o_start     (o_start),
        .o_finish    (o_finish),
        .o_left_edge (o_left_edge),
        .o_y         (o_y)
    );

    assign o_rd_x    = slot_q[i_rd_idx].x;
    assign o_rd_y    = slot_q[i_rd_idx].y;
    assign o_num_pts = num_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;

endmodule

// File: tb/tb_point_detect_ctrl.sv
// Bench for point_detect_ctrl: vector table, random rows against a run-list model, hand-written corner sequences.
module tb_point_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_arm, i_vsync, i_valid;
    logic [9:0] i_x, i_y;
    logic [7:0] i_luma;
    logic       o_start, o_finish;
    logic [9:0] o_left_edge, o_y;
    logic       i_det_finished;
    logic [9:0] i_det_x;
    logic [8:0] i_det_y;
    logic [1:0] i_rd_idx;
    logic [9:0] o_rd_x;
    logic [8:0] o_rd_y;
    logic [2:0] o_num_pts;
    logic       o_busy, o_done;

    always #5 clk = ~clk;

    point_detect_ctrl #(.FRAME_SEL(3)) dut (
        .clk(clk), .rst(rst), .i_arm(i_arm), .i_vsync(i_vsync), .i_valid(i_valid),
        .i_x(i_x), .i_y(i_y), .i_luma(i_luma), .o_start(o_start), .o_finish(o_finish),
        .o_left_edge(o_left_edge), .o_y(o_y), .i_det_finished(i_det_finished),
        .i_det_x(i_det_x), .i_det_y(i_det_y), .i_rd_idx(i_rd_idx), .o_rd_x(o_rd_x),
        .o_rd_y(o_rd_y), .o_num_pts(o_num_pts), .o_busy(o_busy), .o_done(o_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        i_arm = 0; i_vsync = 0; i_valid = 0; i_x = '0; i_y = '0; i_luma = '0;
        i_det_finished = 0; i_det_x = '0; i_det_y = '0;
    endtask

    task automatic pix(input logic v, input int x, input int y, input int l);
        i_valid = v; i_x = 10'(x); i_y = 10'(y); i_luma = 8'(l);
        step();
        i_valid = 0;
    endtask

    task automatic pulse_arm();
        i_arm = 1; step(); i_arm = 0;
    endtask

    task automatic pulse_vsync();
        i_vsync = 1; step(); i_vsync = 0;
    endtask

    task automatic det(input int x, input int y);
        i_det_finished = 1; i_det_x = 10'(x); i_det_y = 9'(y);
        step();
        i_det_finished = 0;
    endtask

    // Pixel-level reference: a row is a bit per x position, runs are maximal bright segments.
    int exp_q[$];
    int got_q[$];
    int fin_cnt;
    int cur_y;

    task automatic observe();
        if (o_start) begin
            got_q.push_back(int'(o_left_edge));
            chk("row_y", int'(o_y), cur_y);
        end
        if (o_finish) fin_cnt++;
    endtask

    typedef struct {
        logic v; int x; int y; int l;
        logic s; logic f; int left; int ey;
    } vec_t;
    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1'b1,  99, 10,  10, 1'b0, 1'b0,   0,  0};
        tbl[1]  = '{1'b1, 100, 10, 250, 1'b1, 1'b0, 100, 10};
        tbl[2]  = '{1'b1, 101, 10, 200, 1'b0, 1'b0, 100, 10};
        tbl[3]  = '{1'b0, 102, 10,   0, 1'b0, 1'b0, 100, 10};
        tbl[4]  = '{1'b1, 109, 10, 255, 1'b0, 1'b0, 100, 10};
        tbl[5]  = '{1'b1, 110, 10, 199, 1'b0, 1'b1, 100, 10};
        tbl[6]  = '{1'b1, 630, 11, 220, 1'b1, 1'b0, 630, 11};
        tbl[7]  = '{1'b1, 639, 11, 220, 1'b0, 1'b1, 630, 11};
        tbl[8]  = '{1'b1,   0, 12,   0, 1'b0, 1'b0, 630, 11};
        tbl[9]  = '{1'b1, 639, 12, 255, 1'b1, 1'b0, 639, 12};
        tbl[10] = '{1'b0,   0, 12,   0, 1'b0, 1'b1, 639, 12};
        tbl[11] = '{1'b1,   5, 12,   0, 1'b0, 1'b0, 639, 12};

        rst = 0; i_rd_idx = '0;
        idle_in();
        step(); step();
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_num", int'(o_num_pts), 0);
        chk("rst_start", int'(o_start), 0);
        chk("rst_finish", int'(o_finish), 0);
        chk("rst_left", int'(o_left_edge), 0);
        chk("rst_rdx", int'(o_rd_x), 0);
        rst = 1;
        step();

        // Arm, count frames; pixels before the selected frame must be ignored.
        pulse_arm();
        chk("arm_busy", int'(o_busy), 1);
        pulse_vsync();
        pix(1, 50, 3, 255);
        chk("wait_no_start", int'(o_start), 0);
        pulse_arm();
        pulse_vsync();
        step();
        chk("wait_no_finish", int'(o_finish), 0);
        pulse_vsync();
        chk("scan_busy", int'(o_busy), 1);
        chk("scan_done", int'(o_done), 0);

        for (int i = 0; i < 12; i++) begin
            pix(tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].l);
            chk($sformatf("tbl%0d_start", i), int'(o_start), int'(tbl[i].s));
            chk($sformatf("tbl%0d_finish", i), int'(o_finish), int'(tbl[i].f));
            chk($sformatf("tbl%0d_left", i), int'(o_left_edge), tbl[i].left);
            chk($sformatf("tbl%0d_y", i), int'(o_y), tbl[i].ey);
        end

        // Random rows near the line end, with valid-low gaps.
        for (int r = 0; r < 20; r++) begin
            logic [19:0] bits;
            bits  = 20'($urandom);
            cur_y = int'($urandom_range(0, 479));
            exp_q.delete(); got_q.delete(); fin_cnt = 0;
            for (int i = 0; i < 20; i++)
                if (bits[i] && (i == 0 || !bits[i-1])) exp_q.push_back(620 + i);
            for (int i = 0; i < 20; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    pix(0, int'($urandom_range(0, 639)), cur_y, int'($urandom_range(0, 255)));
                    observe();
                end
                pix(1, 620 + i, cur_y,
                    bits[i] ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 199)));
                observe();
            end
            for (int k = 0; k < 3; k++) begin
                step();
                observe();
            end
            chk("row_nruns", got_q.size(), exp_q.size());
            for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
                chk("row_left", got_q[k], exp_q[k]);
            chk("row_nfin", fin_cnt, exp_q.size());
        end

        // Fill all slots with a run open; fifth strobe dropped, open run closed once.
        pix(1, 5, 20, 255);
        chk("pre_det_start", int'(o_start), 1);
        fin_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            det(50 + 10 * k, 5 + k);
            if (o_finish) fin_cnt++;
            chk("det_num", int'(o_num_pts), (k < 4) ? k + 1 : 4);
            if (k == 3) begin
                chk("full_done", int'(o_done), 1);
                chk("full_busy", int'(o_busy), 0);
            end
        end
        for (int k = 0; k < 3; k++) begin
            step();
            if (o_finish) fin_cnt++;
        end
        chk("full_close_fin", fin_cnt, 1);
        for (int k = 0; k < 4; k++) begin
            i_rd_idx = 2'(k);
            #1;
            chk("slot_x", int'(o_rd_x), 50 + 10 * k);
            chk("slot_y", int'(o_rd_y), 5 + k);
        end
        i_rd_idx = '0;

        // Re-arm; vsync ends the scan with a run open.
        pulse_arm();
        chk("rearm_busy", int'(o_busy), 1);
        chk("rearm_num", int'(o_num_pts), 0);
        pulse_vsync(); pulse_vsync(); pulse_vsync();
        det(300, 100);
        chk("scan2_num", int'(o_num_pts), 1);
        pix(1, 7, 40, 230);
        chk("scan2_start", int'(o_start), 1);
        fin_cnt = 0;
        pulse_vsync();
        if (o_finish) fin_cnt++;
        chk("vs_done", int'(o_done), 1);
        for (int k = 0; k < 4; k++) begin
            step();
            if (o_finish) fin_cnt++;
        end
        chk("vs_close_fin", fin_cnt, 1);
        chk("vs_num", int'(o_num_pts), 1);
        i_rd_idx = 2'd0; #1;
        chk("vs_slot0_x", int'(o_rd_x), 300);
        chk("vs_slot0_y", int'(o_rd_y), 100);
        i_rd_idx = 2'd1; #1;
        chk("stale_slot1_x", int'(o_rd_x), 60);
        i_rd_idx = '0;

        // Reset asserted mid-run.
        pulse_arm();
        pulse_vsync(); pulse_vsync(); pulse_vsync();
        det(400, 44);
        pix(1, 8, 30, 255);
        chk("mid_start", int'(o_start), 1);
        #2;
        rst = 0;
        #1;
        chk("arst_start", int'(o_start), 0);
        chk("arst_left", int'(o_left_edge), 0);
        chk("arst_y", int'(o_y), 0);
        chk("arst_busy", int'(o_busy), 0);
        chk("arst_num", int'(o_num_pts), 0);
        chk("arst_rdx", int'(o_rd_x), 0);
        step();
        rst = 1;
        fin_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            pix(1, 9 + k, 30, 0);
            if (o_finish) fin_cnt++;
        end
        chk("arst_no_fin", fin_cnt, 0);
        pix(1, 20, 30, 255);
        chk("idle_no_start", int'(o_start), 0);
        chk("idle_busy", int'(o_busy), 0);
        chk("idle_done", int'(o_done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
